mips_mc_ctrl: RTL and testbench

Multicycle main control unit for the MIPS core. It decodes the 6-bit opcode latched in the instruction register and steps the shared datapath through the fetch, decode, execute, memory and writeback phases. It drives every datapath enable and mux select, plus the 2-bit `alu_op` consumed by the ALU control decoder. It stalls in memory phases until the memory returns `mem_ready`.

---
 rtl/mips_mc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl
// Multicycle main control for the MIPS core. A Moore FSM steps the shared
// datapath through fetch / decode / execute / memory / writeback, driving all
// datapath enables and mux selects plus the 2-bit alu_op class.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   opcode[5:0]       IR[31:26], meaningful from DECODE onward
//   mem_ready         memory completes an access in the cycle it is high
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   pc_source[1:0], alu_op[1:0]   datapath controls
//   illegal_op        one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]        current state encoding (debug)
//
// Handshake: a memory request (mem_read / mem_write with iord) is held stable
// in FETCH, MEMRD and MEMWR until mem_ready is seen high; the access completes
// in that cycle and the FSM advances on the following edge. mem_ready is
// ignored in every other state.
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Every output, including the debug state, is held at 0 while rst_n is low
  // so that no request or write enable escapes during reset (FETCH would
  // otherwise raise mem_read).
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    state         = 4'd0;

    if (rst_n) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          // IR and PC+4 are captured only in the cycle the read completes.
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            default: begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          // Only lw/sw reach here; IR still holds the opcode.
          state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          state_d   = S_FETCH;
        end
        default: begin
          // Unreachable encodings recover to FETCH with all outputs low.
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Testbench for mips_mc_ctrl. A reference model expands each instruction
// (opcode plus planned memory stall counts) into the expected per-cycle
// sequence of states and control outputs; the DUT is stepped through the same
// cycles and every cycle's full output vector is compared.
module tb_mips_mc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;

  int vectors = 0;
  int errs    = 0;

  // Expected trace: one entry per cycle.
  bit         mr_q[$];
  logic [5:0] op_q[$];
  logic [20:0] exp_q[$];

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'd0;
  end

  // ---------------- reference model ----------------
  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                 ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC = 6, ST_ALUWB = 7,
                 ST_BRANCH = 8, ST_JUMP = 9;

  function automatic bit is_legal(logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010;
  endfunction

  // Control outputs required in a given phase, from the per-phase table.
  function automatic logic [20:0] exp_vec(int st, bit mr, bit ill);
    logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, sa = 0, il = 0;
    logic [1:0] sb = 0, ps = 0, ao = 0;
    case (st)
      ST_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      ST_DECODE: begin sb = 2'b11; il = ill; end
      ST_MEMADR: begin sa = 1; sb = 2'b10; end
      ST_MEMRD:  begin mrd = 1; io = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; end
      ST_MEMWR:  begin mwr = 1; io = 1; end
      ST_EXEC:   begin sa = 1; ao = 2'b10; end
      ST_ALUWB:  begin rw = 1; rdst = 1; end
      ST_BRANCH: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      ST_JUMP:   begin pw = 1; ps = 2'b10; end
      default:   ;
    endcase
    return {4'(st), pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ps, ao, il};
  endfunction

  task automatic push(int st, bit mr, logic [5:0] op, bit ill);
    mr_q.push_back(mr);
    op_q.push_back(op);
    exp_q.push_back(exp_vec(st, mr, ill));
  endtask

  // Expands one instruction into its cycle sequence. fs/ms are the number of
  // not-ready cycles in the fetch and in the data memory access.
  task automatic build_trace(logic [5:0] op, int fs, int ms);
    for (int i = 0; i < fs; i++) push(ST_FETCH, 0, 6'($urandom), 0);
    push(ST_FETCH, 1, 6'($urandom), 0);
    push(ST_DECODE, 1'($urandom), op, !is_legal(op));
    case (op)
      6'b000000: begin
        push(ST_EXEC, 1'($urandom), op, 0);
        push(ST_ALUWB, 1'($urandom), op, 0);
      end
      6'b100011: begin
        push(ST_MEMADR, 1'($urandom), op, 0);
        for (int i = 0; i < ms; i++) push(ST_MEMRD, 0, op, 0);
        push(ST_MEMRD, 1, op, 0);
        push(ST_MEMWB, 1'($urandom), op, 0);
      end
      6'b101011: begin
        push(ST_MEMADR, 1'($urandom), op, 0);
        for (int i = 0; i < ms; i++) push(ST_MEMWR, 0, op, 0);
        push(ST_MEMWR, 1, op, 0);
      end
      6'b000100: push(ST_BRANCH, 1'($urandom), op, 0);
      6'b000010: push(ST_JUMP, 1'($urandom), op, 0);
      default: ;
    endcase
  endtask

  function automatic logic [5:0] rand_illegal();
    logic [5:0] op;
    do op = 6'($urandom_range(0, 63)); while (is_legal(op));
    return op;
  endfunction

  // ---------------- driver ----------------
  // Drives inputs on the falling edge, samples outputs 1 time unit later.
  task automatic drive_cycle(input bit rn, input bit mr, input logic [5:0] op,
                             output logic [20:0] obs);
    @(negedge clk);
    rst_n     = rn;
    mem_ready = mr;
    opcode    = op;
    #1;
    obs = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal_op};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [20:0] obs, e;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(0, 1, 6'($urandom), obs);
      vectors++;
      if (obs !== 21'd0) begin
        errs++; $display("FAIL reset_init cyc %0d got %h exp %h", i, obs, 21'd0);
      end
    end
    // Walk into JUMP, then reset there for two cycles.
    build_trace(6'b000010, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL reset_walk cyc %0d got %h exp %h", i, obs, e);
      end
    end
    mr_q.delete(); op_q.delete(); exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(0, 1, 6'b000010, obs);
      vectors++;
      if (obs !== 21'd0) begin
        errs++; $display("FAIL reset_in_jump cyc %0d got %h exp %h", i, obs, 21'd0);
      end
    end
    // First cycle after release: fetch request already present.
    drive_cycle(1, 0, 6'($urandom), obs);
    e = exp_vec(ST_FETCH, 0, 0);
    vectors++;
    if (obs !== e) begin
      errs++; $display("FAIL reset_release got %h exp %h", obs, e);
    end
  endtask

  task automatic test_rtype();
    logic [20:0] obs, e;
    build_trace(6'b000000, 0, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL rtype got %h exp %h", obs, e);
      end
    end
  endtask

  task automatic test_lw_stall();
    logic [20:0] obs, e;
    build_trace(6'b100011, 0, 3);
    while (exp_q.size() > 0) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL lw_stall got %h exp %h", obs, e);
      end
    end
  endtask

  task automatic test_sw_beq();
    logic [20:0] obs, e;
    build_trace(6'b101011, 0, 0);
    build_trace(6'b000100, 0, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL sw_beq got %h exp %h", obs, e);
      end
    end
  endtask

  task automatic test_j_illegal();
    logic [20:0] obs, e;
    build_trace(6'b000010, 0, 0);
    build_trace(6'b111111, 0, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL j_illegal got %h exp %h", obs, e);
      end
    end
  endtask

  task automatic test_fetch_stall();
    logic [20:0] obs, e;
    build_trace(6'b000000, 2, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL fetch_stall got %h exp %h", obs, e);
      end
    end
  endtask

  // Reset asserted while a store waits in MEMWR: the write must drop at once.
  task automatic test_midreset();
    logic [20:0] obs, e;
    build_trace(6'b101011, 0, 3);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL midreset_walk cyc %0d got %h exp %h", i, obs, e);
      end
    end
    mr_q.delete(); op_q.delete(); exp_q.delete();
    drive_cycle(0, 0, 6'b101011, obs);
    vectors++;
    if (obs !== 21'd0) begin
      errs++; $display("FAIL midreset_wait got %h exp %h", obs, 21'd0);
    end
    build_trace(6'b100011, 1, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL midreset_after got %h exp %h", obs, e);
      end
    end
  endtask

  task automatic test_random();
    logic [20:0] obs, e;
    logic [5:0]  op;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       op = 6'b000000;
        1:       op = 6'b100011;
        2:       op = 6'b101011;
        3:       op = 6'b000100;
        4:       op = 6'b000010;
        default: op = rand_illegal();
      endcase
      build_trace(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    while (exp_q.size() > 0) begin
      drive_cycle(1, mr_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        errs++; $display("FAIL random got %h exp %h", obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_beq();
    test_j_illegal();
    test_fetch_stall();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
